adc_clip_monitor_ctrl: RTL and testbench
========================================

# adc_clip_monitor_ctrl

Controller that sequences a bank of sticky per-stream ADC clip detectors over programmable measurement windows. It clears the detectors, lets them integrate for `window_len` cycles, captures their flags, clears them again, and publishes a per-window report through a valid/ack handshake. It sits between the parallel-stream clip detector bank (driven by its `det_rst`, read through `ovf_flag`) and the register/readout logic.

## Interface
- `PARALLEL_STREAMS`, 8: number of detector streams / width of `ovf_flag`.
- `WINDOW_WIDTH`, 32: width of `window_len` and the window counter.
- `COUNT_WIDTH`, 16: width of the clipped-window counter.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable. When low, all state holds and `det_rst` is driven 0.
- `start`  in  1  one-cycle pulse; begins measurement from IDLE.
- `stop`  in  1  one-cycle pulse; aborts to IDLE.
- `continuous`  in  1  1 = re-arm automatically after each capture; sampled in CAPTURE.
- `window_len`  in  WINDOW_WIDTH  cycles per window; sampled on `start` and in CAPTURE.
- `ovf_flag`  in  PARALLEL_STREAMS  sticky per-stream clip flags from the detector bank.
- `det_rst`  out  1  clear pulse to the detector bank.
- `busy`  out  1  high in any state other than IDLE.
- `clip_live`  out  1  `|ovf_flag` while in MEASURE, else 0.
- `report_mask`  out  PARALLEL_STREAMS  `ovf_flag` captured at the end of the last window.
- `report_windows`  out  COUNT_WIDTH  saturating count of windows with any clip since `rst`.
- `report_valid`  out  1  report registers hold an unacknowledged capture.
- `report_ack`  in  1  consumer acknowledge.
- `overrun`  out  1  sticky; a capture overwrote an unacknowledged report.

## Operation
- FSM states:
  - IDLE.
  - CLEAR: `det_rst`=1 for exactly one cycle.
  - MEASURE: `det_rst`=0. Counter loads `len_eff-1` and decrements.
  - CAPTURE: one cycle. `det_rst`=1, `report_mask`<=`ovf_flag`, stats update.
- Transitions:
  - IDLE -> CLEAR on `start`.
  - CLEAR -> MEASURE.
  - MEASURE -> CAPTURE when the counter is 0.
  - CAPTURE -> MEASURE if `continuous`=1, else -> IDLE.
- `len_eff = (window_len==0) ? 1 : window_len`.
- `start` outside IDLE is ignored.
- `stop` in any non-IDLE state:
  - Next state is IDLE and no capture occurs.
  - The report registers are untouched.
  - `det_rst` pulses once in the `stop` cycle so the bank is left clear.
- `stop` and `start` in the same IDLE cycle: `stop` wins and the FSM stays in IDLE.
- Stats in CAPTURE:
  - `report_windows` increments by 1 if `|ovf_flag`, saturating at all-ones.
  - `report_valid` is set.
  - If `report_valid` was already 1 and no `report_ack` arrives in the same cycle, `overrun` is set.
- Handshake:
  - `report_ack` clears `report_valid` on the next cycle.
  - `report_ack` while `report_valid`=0 is ignored.
  - Capture and ack in the same cycle: the ack consumes the old report, and `report_valid` stays 1 for the new report.
- `overrun` clears only on `rst`.
- Reset values: FSM=IDLE, counter=0, `det_rst`=0, `busy`=0, `clip_live`=0, `report_mask`=0, `report_windows`=0, `report_valid`=0, `overrun`=0.

## Timing
- `start` at cycle t:
  - CLEAR at t+1.
  - MEASURE occupies t+2 .. t+1+len_eff.
  - CAPTURE at t+2+len_eff.
  - `report_valid`=1 from t+3+len_eff.
- Continuous-mode period is `len_eff+1` cycles: MEASURE plus one CAPTURE.
- The detector sample coinciding with a CAPTURE/CLEAR cycle is cleared and not counted. This one-sample blind spot per window is accepted.
- All outputs are registered; `det_rst` is a registered decode of the next state.
- `ce` low freezes the FSM, counter and report registers. `report_ack` is only honoured when `ce`=1.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE/CLEAR/MEASURE/CAPTURE);
  - the width defaults;
  - the saturating-increment helper.
- One sub-module, `window_counter`: loadable down-counter with a zero flag, WINDOW_WIDTH wide, with `ce`.
- FSM, capture and handshake logic stay in the top level.

## Test plan
- Single window:
  - Stimulus: `window_len`=10, `continuous`=0, `start`; force `ovf_flag`=8'h04 mid-window.
  - Required: `det_rst` pulses at t+1 and t+12; `report_mask`=8'h04; `report_windows`=1; `report_valid` at t+13; back to IDLE.
- Continuous with overrun:
  - Stimulus: `window_len`=4, no ack for three captures; `ovf_flag`=0.
  - Required: captures every 5 cycles; `report_windows`=0; `overrun`=1 after the second capture.
- Same-cycle ack and capture:
  - Stimulus: `report_ack` asserted in the CAPTURE cycle.
  - Required: `report_valid` stays 1; `overrun` stays 0; `report_mask` shows the new value.
- Abort:
  - Stimulus: `stop` at MEASURE cycle 3 of 10.
  - Required: `det_rst`=1 that cycle; IDLE next; `report_valid` and `report_mask` unchanged.
- Edge cases:
  - Stimulus: `window_len`=0 behaves as 1; `COUNT_WIDTH`=2 with 5 clipped windows.
  - Required: `report_windows` saturates at 3.
- Mid-operation reset and clock enable:
  - Stimulus: `rst` in MEASURE; `ce` low for 5 cycles during MEASURE.
  - Required: all outputs return to reset values; the `ce`-low run shifts CAPTURE exactly 5 cycles later.

Source files
------------

// File: rtl/adc_clip_monitor_ctrl_pkg.sv
// Shared definitions for the ADC clip monitor controller.
package adc_clip_monitor_ctrl_pkg;

    localparam int unsigned PARALLEL_STREAMS_DEF = 8;
    localparam int unsigned WINDOW_WIDTH_DEF     = 32;
    localparam int unsigned COUNT_WIDTH_DEF      = 16;

    // Widest counter the saturating helper can handle.
    localparam int unsigned SAT_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    // Increment val, holding at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_inc(
        input logic [SAT_MAX_WIDTH-1:0] val,
        input int unsigned              width
    );
        logic [SAT_MAX_WIDTH-1:0] max_val;
        if (width >= SAT_MAX_WIDTH) begin
            max_val = '1;
        end else begin
            max_val = (SAT_MAX_WIDTH'(1) << width) - SAT_MAX_WIDTH'(1);
        end
        return (val >= max_val) ? max_val : val + SAT_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/adc_clip_monitor_ctrl_window.sv
// Loadable down-counter timing one measurement window.
module window_counter
    import adc_clip_monitor_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WINDOW_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero_c
);

    // Load has priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ce) begin
            if (load) begin
                count <= load_val;
            end else if (dec && (count != '0)) begin
                count <= count - WIDTH'(1);
            end
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/adc_clip_monitor_ctrl.sv
// Sequences sticky clip detectors over measurement windows and publishes reports.
module adc_clip_monitor_ctrl
    import adc_clip_monitor_ctrl_pkg::*;
#(
    parameter int unsigned PARALLEL_STREAMS = PARALLEL_STREAMS_DEF,
    parameter int unsigned WINDOW_WIDTH     = WINDOW_WIDTH_DEF,
    parameter int unsigned COUNT_WIDTH      = COUNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        continuous,
    input  logic [WINDOW_WIDTH-1:0]     window_len,
    input  logic [PARALLEL_STREAMS-1:0] ovf_flag,
    output logic                        det_rst,
    output logic                        busy,
    output logic                        clip_live,
    output logic [PARALLEL_STREAMS-1:0] report_mask,
    output logic [COUNT_WIDTH-1:0]      report_windows,
    output logic                        report_valid,
    input  logic                        report_ack,
    output logic                        overrun
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    cnt_load;
    logic                    cnt_dec;
    logic                    cnt_zero;
    logic [WINDOW_WIDTH-1:0] cnt_val;
    logic [WINDOW_WIDTH-1:0] len_m1;
    logic                    stop_act;
    logic                    capture;
    logic                    any_clip;

    // A zero-length window is treated as one cycle long.
    assign len_m1   = (window_len == '0) ? '0 : window_len - WINDOW_WIDTH'(1);
    assign stop_act = stop && (state != ST_IDLE);
    assign capture  = (state == ST_CAPTURE) && !stop;
    assign any_clip = |ovf_flag;

    window_counter #(
        .WIDTH (WINDOW_WIDTH)
    ) u_window_counter (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .load     (cnt_load),
        .load_val (len_m1),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero_c   (cnt_zero)
    );

    // Next-state and counter control; stop overrides everything outside IDLE.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_CLEAR;
                    cnt_load  = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (cnt_zero) begin
                    state_nxt = ST_CAPTURE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (continuous) begin
                    state_nxt = ST_MEASURE;
                    cnt_load  = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (stop_act) begin
            state_nxt = ST_IDLE;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
        end
    end

    // State register, registered output decode, capture and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            det_rst        <= 1'b0;
            busy           <= 1'b0;
            clip_live      <= 1'b0;
            report_mask    <= '0;
            report_windows <= '0;
            report_valid   <= 1'b0;
            overrun        <= 1'b0;
        end else if (ce) begin
            state     <= state_nxt;
            busy      <= (state_nxt != ST_IDLE);
            det_rst   <= (state_nxt == ST_CLEAR) || (state_nxt == ST_CAPTURE) || stop_act;
            clip_live <= (state_nxt == ST_MEASURE) && any_clip;
            if (capture) begin
                report_mask  <= ovf_flag;
                report_valid <= 1'b1;
                if (any_clip) begin
                    report_windows <= COUNT_WIDTH'(sat_inc(SAT_MAX_WIDTH'(report_windows), COUNT_WIDTH));
                end
                if (report_valid && !report_ack) begin
                    overrun <= 1'b1;
                end
            end else if (report_ack) begin
                report_valid <= 1'b0;
            end
        end else begin
            det_rst <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_clip_monitor_ctrl.sv
// Bench for adc_clip_monitor_ctrl: window table plus multi-cycle corner sequences.
module tb_adc_clip_monitor_ctrl;

    localparam int unsigned PS = 8;
    localparam int unsigned WW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          start;
    logic          stop;
    logic          continuous;
    logic          report_ack;
    logic [WW-1:0] window_len;
    logic [PS-1:0] ovf_flag;

    logic          det_rst, busy, clip_live, report_valid, overrun;
    logic [PS-1:0] report_mask;
    logic [CW-1:0] report_windows;

    logic          s_det_rst, s_busy, s_clip_live, s_valid, s_overrun;
    logic [PS-1:0] s_mask;
    logic [1:0]    s_win;

    adc_clip_monitor_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .window_len     (window_len),
        .ovf_flag       (ovf_flag),
        .det_rst        (det_rst),
        .busy           (busy),
        .clip_live      (clip_live),
        .report_mask    (report_mask),
        .report_windows (report_windows),
        .report_valid   (report_valid),
        .report_ack     (report_ack),
        .overrun        (overrun)
    );

    // Narrow-counter copy driven identically, used for saturation.
    adc_clip_monitor_ctrl #(
        .COUNT_WIDTH (2)
    ) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .window_len     (window_len),
        .ovf_flag       (ovf_flag),
        .det_rst        (s_det_rst),
        .busy           (s_busy),
        .clip_live      (s_clip_live),
        .report_mask    (s_mask),
        .report_windows (s_win),
        .report_valid   (s_valid),
        .report_ack     (report_ack),
        .overrun        (s_overrun)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  mask;
        logic [15:0] win;
        logic [1:0]  sat;
        logic        ovr;
        logic        pre;
    } exp_t;

    typedef struct {
        int unsigned len;
        logic [7:0]  ovf;
        int unsigned at;
        logic [7:0]  mask;
        logic        clip;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[5];
    logic [15:0] sb_win;
    logic [1:0]  sb_sat;
    logic [7:0]  last_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) tick();
    endtask

    task automatic push(input int unsigned c, input logic [7:0] m, input logic clip,
                        input logic ovr, input logic pre);
        if (clip) begin
            if (sb_win != 16'hffff) sb_win = sb_win + 16'd1;
            if (sb_sat != 2'd3)     sb_sat = sb_sat + 2'd1;
        end
        sb.push_back('{cyc: c, mask: m, win: sb_win, sat: sb_sat, ovr: ovr, pre: pre});
        last_mask = m;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_det_rst"},   32'(det_rst),        32'd0);
        chk({tag, "_busy"},      32'(busy),           32'd0);
        chk({tag, "_clip_live"}, 32'(clip_live),      32'd0);
        chk({tag, "_mask"},      32'(report_mask),    32'd0);
        chk({tag, "_windows"},   32'(report_windows), 32'd0);
        chk({tag, "_valid"},     32'(report_valid),   32'd0);
        chk({tag, "_overrun"},   32'(overrun),        32'd0);
        chk({tag, "_sat_win"},   32'(s_win),          32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst       = 1'b0;
        sb_win    = '0;
        sb_sat    = '0;
        last_mask = '0;
        check_reset_outputs("reset");
        tick();
    endtask

    // One non-continuous window, acknowledged after its report appears.
    task automatic run_window(input int unsigned len, input logic [7:0] ovf, input int unsigned at,
                              input logic [7:0] m, input logic clip);
        int unsigned t;
        int unsigned le;
        t  = cyc;
        le = (len == 0) ? 1 : len;
        push(t + 3 + le, m, clip, 1'b0, 1'b1);
        window_len = WW'(len);
        continuous = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("clr_pulse", 32'(det_rst), 32'd1);
        wait_cyc(t + 2 + at);
        ovf_flag = ovf;
        wait_cyc(t + 2 + le);
        @(negedge clk);
        chk("cap_pulse", 32'(det_rst), 32'd1);
        chk("cap_busy",  32'(busy),    32'd1);
        tick();
        ovf_flag   = '0;
        report_ack = 1'b1;
        tick();
        report_ack = 1'b0;
        @(negedge clk);
        chk("ack_clear",  32'(report_valid), 32'd0);
        chk("idle_after", 32'(busy),         32'd0);
        tick();
    endtask

    // Scoreboard: compare each expected report on the cycle it must be visible.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            if (sb[0].pre && (cyc + 1 == sb[0].cyc))
                chk("valid_early", 32'(report_valid), 32'd0);
            if (cyc == sb[0].cyc) begin
                e = sb.pop_front();
                chk("cap_valid",   32'(report_valid),   32'd1);
                chk("cap_mask",    32'(report_mask),    32'(e.mask));
                chk("cap_windows", 32'(report_windows), 32'(e.win));
                chk("sat_windows", 32'(s_win),          32'(e.sat));
                chk("overrun",     32'(overrun),        32'(e.ovr));
            end else if (cyc > sb[0].cyc) begin
                chk("sb_missed", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int unsigned t;
        logic [7:0]  prev;

        rst        = 1'b1;
        ce         = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        continuous = 1'b0;
        report_ack = 1'b0;
        window_len = '0;
        ovf_flag   = '0;
        sb_win     = '0;
        sb_sat     = '0;
        last_mask  = '0;

        vecs[0] = '{len: 10, ovf: 8'h04, at: 5, mask: 8'h04, clip: 1'b1};
        vecs[1] = '{len: 3,  ovf: 8'h00, at: 0, mask: 8'h00, clip: 1'b0};
        vecs[2] = '{len: 1,  ovf: 8'h81, at: 0, mask: 8'h81, clip: 1'b1};
        vecs[3] = '{len: 0,  ovf: 8'h10, at: 0, mask: 8'h10, clip: 1'b1};
        vecs[4] = '{len: 7,  ovf: 8'hff, at: 6, mask: 8'hff, clip: 1'b1};

        do_reset();

        for (int i = 0; i < 5; i++)
            run_window(vecs[i].len, vecs[i].ovf, vecs[i].at, vecs[i].mask, vecs[i].clip);

        // Ack arriving in the same cycle as the next capture.
        t          = cyc;
        window_len = 32'd3;
        continuous = 1'b1;
        start      = 1'b1;
        push(t + 6,  8'h01, 1'b1, 1'b0, 1'b1);
        push(t + 10, 8'h22, 1'b1, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        wait_cyc(t + 2);
        ovf_flag = 8'h01;
        wait_cyc(t + 6);
        ovf_flag   = '0;
        continuous = 1'b0;
        wait_cyc(t + 7);
        ovf_flag = 8'h22;
        wait_cyc(t + 9);
        report_ack = 1'b1;
        tick();
        report_ack = 1'b0;
        ovf_flag   = '0;
        @(negedge clk);
        chk("samecyc_idle", 32'(busy), 32'd0);
        tick();
        report_ack = 1'b1;
        tick();
        report_ack = 1'b0;
        @(negedge clk);
        chk("samecyc_ack", 32'(report_valid), 32'd0);
        tick();

        // Abort on the third MEASURE cycle of a 10-cycle window.
        t          = cyc;
        prev       = last_mask;
        window_len = 32'd10;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc(t + 3);
        ovf_flag = 8'h40;
        wait_cyc(t + 4);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        @(negedge clk);
        chk("abort_det_rst", 32'(det_rst),      32'd1);
        chk("abort_idle",    32'(busy),         32'd0);
        chk("abort_valid",   32'(report_valid), 32'd0);
        chk("abort_mask",    32'(report_mask),  32'(prev));
        tick();
        @(negedge clk);
        chk("abort_one_pulse", 32'(det_rst), 32'd0);
        wait_cyc(t + 14);
        @(negedge clk);
        chk("abort_no_cap_valid", 32'(report_valid), 32'd0);
        chk("abort_no_cap_mask",  32'(report_mask),  32'(prev));
        ovf_flag = '0;
        tick();

        // stop beats start in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        chk("stop_wins_busy",    32'(busy),    32'd0);
        chk("stop_wins_det_rst", 32'(det_rst), 32'd0);
        tick();

        // Clock enable low for 5 MEASURE cycles delays capture by 5.
        t          = cyc;
        window_len = 32'd10;
        start      = 1'b1;
        push(t + 18, 8'h10, 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        wait_cyc(t + 3);
        ovf_flag = 8'h10;
        wait_cyc(t + 4);
        ce = 1'b0;
        wait_cyc(t + 9);
        ce = 1'b1;
        wait_cyc(t + 12);
        @(negedge clk);
        chk("ce_no_early_cap", 32'(det_rst), 32'd0);
        chk("ce_still_busy",   32'(busy),    32'd1);
        wait_cyc(t + 17);
        @(negedge clk);
        chk("ce_cap_pulse", 32'(det_rst), 32'd1);
        tick();
        ovf_flag   = '0;
        report_ack = 1'b1;
        tick();
        report_ack = 1'b0;
        @(negedge clk);
        chk("ce_ack", 32'(report_valid), 32'd0);
        tick();

        // Continuous mode, no acks: overrun after the second capture.
        t          = cyc;
        window_len = 32'd4;
        continuous = 1'b1;
        start      = 1'b1;
        push(t + 7,  8'h00, 1'b0, 1'b0, 1'b1);
        push(t + 12, 8'h00, 1'b0, 1'b1, 1'b0);
        push(t + 17, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        start = 1'b0;
        wait_cyc(t + 17);
        stop = 1'b1;
        tick();
        stop       = 1'b0;
        continuous = 1'b0;
        @(negedge clk);
        chk("cont_stop_det_rst", 32'(det_rst), 32'd1);
        chk("cont_stop_idle",    32'(busy),    32'd0);
        chk("cont_overrun_held", 32'(overrun), 32'd1);
        tick();
        report_ack = 1'b1;
        tick();
        report_ack = 1'b0;

        // Saturation of the narrow counter with zero-length windows.
        do_reset();
        for (int i = 0; i < 5; i++)
            run_window(0, 8'h08, 0, 8'h08, 1'b1);
        @(negedge clk);
        chk("sat_final", 32'(s_win),          32'd3);
        chk("win_final", 32'(report_windows), 32'd5);
        tick();

        // Reset in the middle of MEASURE.
        t          = cyc;
        window_len = 32'd10;
        start      = 1'b1;
        tick();
        start = 1'b0;
        wait_cyc(t + 2);
        ovf_flag = 8'h02;
        wait_cyc(t + 4);
        @(negedge clk);
        chk("midrst_clip_live", 32'(clip_live), 32'd1);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        sb_win    = '0;
        sb_sat    = '0;
        last_mask = '0;
        check_reset_outputs("midrst");
        ovf_flag = '0;
        tick();
        tick();

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
